// File: rtl/xcvr_freq_meter_pkg.sv
// xcvr_freq_meter_pkg: CSR addresses, CTRL/STATUS bit positions and FSM states for xcvr_clkout_freq_meter
package xcvr_freq_meter_pkg;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_GATE   = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_ABORT = 2;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF  = 2;
  typedef enum logic [1:0] {IDLE, GATE, DONE} state_e;
endpackage

// File: rtl/xcvr_clkout_freq_meter_if.sv
// xcvr_clkout_freq_meter_if: Avalon-MM CSR bus (address, read, write, writedata, readdata) with master/slave modports
interface xcvr_clkout_freq_meter_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
  modport slave (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);
endinterface

// File: rtl/xcvr_freq_meter_sync.sv
// xcvr_freq_meter_sync: two-flop synchroniser plus registered rising-edge detector (clk, reset_n, async_in -> rise_pulse)
module xcvr_freq_meter_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);
  logic [2:0] sync_q;
  logic       rise_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end
  assign rise_pulse = rise_q;
endmodule

// File: rtl/xcvr_clkout_freq_meter.sv
// xcvr_clkout_freq_meter: gated edge-count frequency meter with Avalon-MM CSRs (clk, reset_n, sample_clk, avs slave, meas_done); continuous mode when XCVR_FREQ_METER_CONT_EN is defined
module xcvr_clkout_freq_meter
  import xcvr_freq_meter_pkg::*;
#(
  parameter int COUNT_W      = 32,
  parameter int GATE_W       = 32,
  parameter int DEFAULT_GATE = 100000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            sample_clk,
  xcvr_clkout_freq_meter_if.slave         avs,
  output logic                            meas_done
);
  state_e               state_q, state_d;
  logic [GATE_W-1:0]    timer_q, timer_d, gate_q, gate_d, gate_load;
  logic [COUNT_W-1:0]   cnt_q, cnt_d, result_q, result_d;
  logic                 sat_q, sat_d, ovf_q, ovf_d, done_q, done_d, md_q, md_d;
  logic [31:0]          rdata_q, rdata_d, wdata;
  logic                 rise, wr_ctrl, wr_status, wr_gate, start, abort, restart, busy, cont_q;
  xcvr_freq_meter_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (sample_clk),
    .rise_pulse(rise)
  );
  assign wdata     = avs.avs_writedata;
  assign wr_ctrl   = avs.avs_write && avs.avs_address == ADDR_CTRL;
  assign wr_status = avs.avs_write && avs.avs_address == ADDR_STATUS;
  assign wr_gate   = avs.avs_write && avs.avs_address == ADDR_GATE;
  assign abort     = wr_ctrl & wdata[CTRL_ABORT];
  assign start     = wr_ctrl & wdata[CTRL_START] & ~wdata[CTRL_ABORT];
  assign busy      = state_q != IDLE;
  assign gate_load = gate_q == '0 ? GATE_W'(1) : gate_q;
`ifdef XCVR_FREQ_METER_CONT_EN
  logic cont_d;
  assign cont_d = wr_ctrl ? wdata[CTRL_CONT] : cont_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cont_q <= 1'b0;
    else cont_q <= cont_d;
  end
`else
  assign cont_q = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = done_q & ~(wr_status & wdata[ST_DONE]);
    restart  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start ? GATE : IDLE;
        restart = start;
      end
      GATE: begin
        state_d = abort ? IDLE : timer_q == GATE_W'(1) ? DONE : GATE;
        timer_d = timer_q - 1'b1;
        if (rise) begin
          cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
          sat_d = sat_q | &cnt_q;
        end
      end
      DONE: begin
        state_d = !abort && cont_q ? GATE : IDLE;
        restart = !abort && cont_q;
        if (!abort) begin
          result_d = cnt_q;
          ovf_d    = sat_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      timer_d = gate_load;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end
  end
  assign md_d    = state_q == DONE && !abort;
  assign gate_d  = wr_gate && !busy ? wdata[GATE_W-1:0] : gate_q;
  assign rdata_d = !avs.avs_read ? 32'd0 :
                   avs.avs_address == ADDR_CTRL   ? {30'd0, cont_q, 1'b0} :
                   avs.avs_address == ADDR_STATUS ? {29'd0, ovf_q, done_q, busy} :
                   avs.avs_address == ADDR_GATE   ? 32'(gate_q) : 32'(result_q);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      md_q     <= 1'b0;
      gate_q   <= GATE_W'(DEFAULT_GATE);
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      md_q     <= md_d;
      gate_q   <= gate_d;
      rdata_q  <= rdata_d;
    end
  end
  assign avs.avs_readdata = rdata_q;
  assign meas_done        = md_q;
endmodule

// File: doc/xcvr_clkout_freq_meter.md
# xcvr_clkout_freq_meter

Frequency meter that consumes the sampled transceiver clock (`tx_clkout2_sample` / `rx_clkout2_a`) produced by the clkout2 converter stage. It counts that clock's rising edges over a programmable gate window in the management clock domain. The result is exposed through a small Avalon-MM CSR slave, so the test system can report TX/RX recovered-clock rates. The input is asynchronous to `clk` and is synchronised internally.

## Interface
- `COUNT_W`, 32: width of the edge counter and RESULT field (8..32).
- `GATE_W`, 32: width of the gate-length register (8..32).
- `DEFAULT_GATE`, 100000: reset value of the GATE register, in `clk` cycles.
- `clk`  in  1  management clock; all logic is in this domain.
- `reset_n`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk` externally.
- `sample_clk`  in  1  measured clock, asynchronous; rising-edge rate must not exceed `clk`/4.
- `avs_address`  in  2  CSR word address.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, fixed read latency 1, no waitrequest.
- `meas_done`  out  1  one-cycle pulse when a window completes.

## Operation
- CSR map:
  - 0 CTRL: bit0 START (write-1 pulse), bit1 CONT (R/W, macro only), bit2 ABORT (write-1 pulse); reads return CONT only.
  - 1 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear), bit2 OVF (RO, from last completed window).
  - 2 GATE: R/W. Writes are ignored while BUSY. A value of 0 is treated as 1.
  - 3 RESULT: RO, zero-extended edge count of the last completed window.
- FSM states: IDLE, GATE, DONE.
  - IDLE→GATE on START. The counter clears and the gate timer loads GATE.
  - GATE: counts synchronised rising edges and decrements the timer. Timer reaching 1 → DONE.
  - DONE (1 cycle): RESULT←count, OVF←saturated flag, DONE←1, `meas_done` pulses. Next state is GATE if CONT=1, otherwise IDLE.
- BUSY = state≠IDLE.
- Edge counter saturates at all-ones; the saturation flag sets and stays set until the next window starts.
- Edges arriving in the DONE or IDLE cycles are not counted. Accuracy is ±1 edge.
- Simultaneous and boundary events:
  - START while BUSY: ignored.
  - ABORT while BUSY: → IDLE next cycle; RESULT, OVF and DONE are unchanged.
  - START and ABORT in the same write: ABORT wins.
  - DONE W1C in the same cycle as DONE set: set wins.
  - Reset mid-window: everything returns to reset values; no partial result is kept.
- Reset values: `avs_readdata`=0, `meas_done`=0, CONT=0, BUSY=0, DONE=0, OVF=0, RESULT=0, GATE=`DEFAULT_GATE`, state IDLE.

## Timing
- `sample_clk` path: two-flop synchroniser, then a registered edge detector. A rising edge is seen as a 1-cycle pulse 3–4 `clk` cycles after the input rises.
- A window lasts exactly GATE cycles in GATE state.
- Cycle accounting from the START write cycle W:
  - GATE state begins at W+1.
  - DONE state occurs at W+1+GATE.
  - `meas_done` and the RESULT update are visible at W+2+GATE.
- Continuous mode: windows repeat every GATE+1 cycles.
- A read issued in cycle R returns data in cycle R+1. Register state is sampled at R.

## Configuration
- `XCVR_FREQ_METER_CONT_EN` defined: the CONT bit exists, and the DONE→GATE auto-restart is enabled.
- Not defined: CONT reads 0, CONT writes are ignored, and DONE always goes to IDLE.

## Structure
- Package `xcvr_freq_meter_pkg` holds:
  - CSR address constants;
  - CTRL and STATUS bit positions;
  - the FSM state enum (IDLE/GATE/DONE).
- Sub-module `xcvr_freq_meter_sync` holds the synchroniser and rising-edge detector, with ports `clk`, `reset_n`, `async_in`, `rise_pulse`.
- The top level contains the FSM, gate timer, saturating counter and CSR decode.

## Test plan
- GATE=1000, `sample_clk` rising every 8 `clk` cycles, START → RESULT=125±1, DONE=1, OVF=0, `meas_done` at W+1002.
- `COUNT_W`=8, GATE=4000, period 8 → RESULT=255, OVF=1.
- ABORT at cycle 300 of a GATE=1000 window → BUSY=0 after one cycle, RESULT keeps its previous value 125, DONE stays 0.
- While BUSY: write GATE=50 → readback is still 1000; a second START does not restart the window (`meas_done` still at W+1002). GATE=0 → the window lasts 1 cycle.
- `reset_n` asserted mid-window → all outputs and registers read back their reset values; GATE=100000.
- With the macro, CONT=1 and GATE=200 → `meas_done` every 201 cycles until CONT is cleared. Without the macro, CONT reads 0 and only a single window runs.
